axi_lite_mul_slave: RTL and testbench

AXI4-Lite responder (slave) hosting the hardware multiplier's register file. It is the target end of the AXI4-Lite master BFM transactions issued by the block-design bench. It accepts single-beat writes and reads, runs a 16x16 unsigned iterative shift-add multiply when software starts it, and raises a level interrupt on completion. It sits behind the interconnect inside the hw_mul IP and drives the design's irq line.

---
 rtl/axi_lite_mul_slave_if.sv | 46 ++++
 rtl/axi_lite_mul_slave.sv | 196 +++++++++++++++++++
 tb/tb_axi_lite_mul_slave.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_mul_slave_if.sv
// AXI4-Lite bundle between the hw_mul register file and its interconnect master.
// Latency: none, wires only.
// Backpressure: standard AXI4-Lite VALID/READY on all five channels.
// Ports: AW (AWADDR/AWPROT/AWVALID/AWREADY), W (WDATA/WSTRB/WVALID/WREADY),
//        B (BRESP/BVALID/BREADY), AR (ARADDR/ARPROT/ARVALID/ARREADY),
//        R (RDATA/RRESP/RVALID/RREADY). Clock and reset stay outside the bundle.
interface axi_lite_mul_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]                      AWPROT;
  logic                            AWVALID;
  logic                            AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                            WVALID;
  logic                            WREADY;
  logic [1:0]                      BRESP;
  logic                            BVALID;
  logic                            BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]                      ARPROT;
  logic                            ARVALID;
  logic                            ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                      RRESP;
  logic                            RVALID;
  logic                            RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID,    output WREADY,
    output BRESP, BVALID,           input  BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID,    input  RREADY
  );

  modport master (
    output AWADDR, AWPROT, AWVALID, input  AWREADY,
    output WDATA, WSTRB, WVALID,    input  WREADY,
    input  BRESP, BVALID,           output BREADY,
    output ARADDR, ARPROT, ARVALID, input  ARREADY,
    input  RDATA, RRESP, RVALID,    output RREADY
  );
endinterface

// File: rtl/axi_lite_mul_slave.sv
// AXI4-Lite register file for the iterative 16x16 shift-add multiplier with level irq.
// Latency: BVALID one cycle after the later of AW/W; RVALID one cycle after AR; multiply 18 cycles.
// Backpressure: BVALID/RVALID hold until BREADY/RREADY; no new AW/W while BVALID, no new AR while RVALID.
// Ports: S_AXI_ACLK clock, S_AXI_ARESETN async active-low reset, S_AXI slave bundle,
//        irq = registered DONE & IRQ_EN.
// Map: 0x0 A (RW), 0x4 B (RW), 0x8 CTRL {IRQ_EN, DONE(W1C), START/BUSY}, 0xC RESULT (RO).
module axi_lite_mul_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int OPERAND_WIDTH      = 16
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  axi_lite_mul_slave_if.slave        S_AXI,
  output logic                       irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam int PW = 2 * OPERAND_WIDTH;
  localparam int CW = $clog2(OPERAND_WIDTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // ---------------- write channel ----------------
  logic          awGot, wGot, bValid;
  logic [AW-1:0] awAddrQ;
  logic [DW-1:0] wDataQ;
  logic [SW-1:0] wStrbQ;
  logic          awReady, wReady, awHs, wHs, wrEn;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic [SW-1:0] wrStrb;
  logic [1:0]    wrIdx;

  assign awReady = S_AXI.AWVALID & ~awGot & ~bValid;
  assign wReady  = S_AXI.WVALID  & ~wGot  & ~bValid;
  assign awHs    = awReady;
  assign wHs     = wReady;

  // A channel captured in an earlier cycle is replayed from its holding register.
  assign wrAddr = awGot ? awAddrQ : S_AXI.AWADDR;
  assign wrData = wGot  ? wDataQ  : S_AXI.WDATA;
  assign wrStrb = wGot  ? wStrbQ  : S_AXI.WSTRB;
  assign wrEn   = (awGot | awHs) & (wGot | wHs);
  assign wrIdx  = wrAddr[3:2];

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awGot   <= 1'b0;
      wGot    <= 1'b0;
      bValid  <= 1'b0;
      awAddrQ <= '0;
      wDataQ  <= '0;
      wStrbQ  <= '0;
    end else begin
      if (bValid && S_AXI.BREADY) bValid <= 1'b0;
      if (wrEn) begin
        awGot  <= 1'b0;
        wGot   <= 1'b0;
        bValid <= 1'b1;
      end else begin
        if (awHs) begin
          awGot   <= 1'b1;
          awAddrQ <= S_AXI.AWADDR;
        end
        if (wHs) begin
          wGot   <= 1'b1;
          wDataQ <= S_AXI.WDATA;
          wStrbQ <= S_AXI.WSTRB;
        end
      end
    end
  end

  assign S_AXI.AWREADY = awReady;
  assign S_AXI.WREADY  = wReady;
  assign S_AXI.BVALID  = bValid;
  assign S_AXI.BRESP   = 2'b00;

  // ---------------- registers ----------------
  logic [DW-1:0]            regA, regB;
  logic [PW-1:0]            resultQ;
  logic                     done, irqEn;
  logic [1:0]               state;
  logic [PW-1:0]            mcand, acc;
  logic [OPERAND_WIDTH-1:0] mplier;
  logic [CW-1:0]            cnt;
  logic                     busy, ctrlWr, startReq, finish;

  assign busy     = (state != ST_IDLE);
  assign ctrlWr   = wrEn && (wrIdx == 2'd2) && wrStrb[0];
  assign startReq = ctrlWr && wrData[0] && (state == ST_IDLE);
  assign finish   = (state == ST_FINISH);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      regA  <= '0;
      regB  <= '0;
      irqEn <= 1'b0;
      done  <= 1'b0;
    end else begin
      for (int i = 0; i < SW; i++) begin
        if (wrEn && wrIdx == 2'd0 && wrStrb[i]) regA[i*8 +: 8] <= wrData[i*8 +: 8];
        if (wrEn && wrIdx == 2'd1 && wrStrb[i]) regB[i*8 +: 8] <= wrData[i*8 +: 8];
      end
      if (ctrlWr) irqEn <= wrData[2];
      // Completion beats a simultaneous W1C so a finished result is never lost.
      if (finish)                    done <= 1'b1;
      else if (ctrlWr && wrData[1])  done <= 1'b0;
    end
  end

  // ---------------- multiplier FSM ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state   <= ST_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      resultQ <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (startReq) begin
            // Working copies decouple the run from later writes to A/B.
            mcand  <= PW'(regA[OPERAND_WIDTH-1:0]);
            mplier <= regB[OPERAND_WIDTH-1:0];
            acc    <= '0;
            cnt    <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(OPERAND_WIDTH - 1)) state <= ST_FINISH;
        end
        ST_FINISH: begin
          resultQ <= acc;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) irq <= 1'b0;
    else                irq <= done & irqEn;
  end

  // ---------------- read channel ----------------
  logic          rValid, arReady;
  logic [DW-1:0] rData, rdMux;

  assign arReady = S_AXI.ARVALID & ~rValid;

  always_comb begin
    rdMux = '0;
    case (S_AXI.ARADDR[3:2])
      2'd0:    rdMux = regA;
      2'd1:    rdMux = regB;
      2'd2:    rdMux = {{(DW-3){1'b0}}, irqEn, done, busy};
      default: rdMux = DW'(resultQ);
    endcase
  end

  // Sampling the current register values gives read-before-write on a same-cycle collision.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rValid <= 1'b0;
      rData  <= '0;
    end else if (arReady) begin
      rValid <= 1'b1;
      rData  <= rdMux;
    end else if (rValid && S_AXI.RREADY) begin
      rValid <= 1'b0;
    end
  end

  assign S_AXI.ARREADY = arReady;
  assign S_AXI.RVALID  = rValid;
  assign S_AXI.RDATA   = rData;
  assign S_AXI.RRESP   = 2'b00;

  logic unusedBits;
  assign unusedBits = ^{S_AXI.AWPROT, S_AXI.ARPROT, wrAddr[1:0], S_AXI.ARADDR[1:0]};

endmodule

// File: tb/tb_axi_lite_mul_slave.sv
// Self-checking bench for axi_lite_mul_slave: directed register/timing steps plus random multiplies.
// Expected values come from a cycle-stamped register model with plain-arithmetic products.
// Drives inputs #1 after the rising edge; samples handshakes on the falling edge.
module tb_axi_lite_mul_slave;

  logic tb_ACLK = 1'b0;
  logic tb_ARESETN = 1'b0;
  logic irqOut;
  int   cyc = 0;
  int   checkCnt = 0;
  int   passCnt = 0;
  int   failCnt = 0;

  always #5 tb_ACLK = ~tb_ACLK;
  always @(posedge tb_ACLK) cyc <= cyc + 1;

  axi_lite_mul_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) axiBus ();

  axi_lite_mul_slave #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .OPERAND_WIDTH(16)
  ) dut (
    .S_AXI_ACLK(tb_ACLK),
    .S_AXI_ARESETN(tb_ARESETN),
    .S_AXI(axiBus.slave),
    .irq(irqOut)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400000 ns");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0] mA, mB, mResult, mProd;
  bit          mDone, mIrqEn, mRun;
  int          mStart;

  function automatic void modelReset();
    mA = 0; mB = 0; mResult = 0; mProd = 0;
    mDone = 0; mIrqEn = 0; mRun = 0; mStart = 0;
  endfunction

  // A run started by a write committed in cycle s reports its result from cycle s+18.
  function automatic void advance(input int x);
    if (mRun && x >= mStart + 18) begin
      mResult = mProd;
      mDone   = 1;
      mRun    = 0;
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic void modelWrite(input logic [3:0] addr, input logic [31:0] d,
                                     input logic [3:0] s, input int c);
    advance(c);
    case (addr[3:2])
      2'd0: mA = merge(mA, d, s);
      2'd1: mB = merge(mB, d, s);
      2'd2: if (s[0]) begin
        if (d[1]) mDone = 0;
        mIrqEn = d[2];
        if (d[0] && !mRun) begin
          mRun   = 1;
          mStart = c;
          mProd  = {16'h0, mA[15:0]} * {16'h0, mB[15:0]};
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] expRead(input logic [3:0] addr, input int x);
    advance(x);
    case (addr[3:2])
      2'd0:    return mA;
      2'd1:    return mB;
      2'd2:    return {29'h0, mIrqEn, mDone, (mRun && x > mStart)};
      default: return mResult;
    endcase
  endfunction

  // ---------------- check + bus tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) begin
      passCnt++;
    end else begin
      failCnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic stepTo(input int n);
    while (cyc < n) begin
      @(posedge tb_ACLK); #1;
    end
  endtask

  task automatic axiWrite(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s,
                          input int holdB, output int commitCyc);
    bit awDone, wDone, awNow, wNow;
    int n;
    axiBus.AWADDR = addr; axiBus.AWVALID = 1'b1;
    axiBus.WDATA  = d;    axiBus.WSTRB   = s;    axiBus.WVALID = 1'b1;
    awDone = 0; wDone = 0; n = 0; commitCyc = cyc;
    while (!(awDone && wDone) && n < 20) begin
      @(negedge tb_ACLK);
      awNow = axiBus.AWVALID && axiBus.AWREADY;
      wNow  = axiBus.WVALID && axiBus.WREADY;
      if (awNow) awDone = 1;
      if (wNow)  wDone = 1;
      if (awNow || wNow) commitCyc = cyc;
      @(posedge tb_ACLK); #1;
      if (awDone) axiBus.AWVALID = 1'b0;
      if (wDone)  axiBus.WVALID  = 1'b0;
      n++;
    end
    axiBus.AWVALID = 1'b0; axiBus.WVALID = 1'b0;
    check("aw_w_accepted", {30'h0, awDone, wDone}, 32'h3);
    modelWrite(addr, d, s, commitCyc);
    n = 0;
    while (!axiBus.BVALID && n < 20) begin
      @(posedge tb_ACLK); #1; n++;
    end
    check("bvalid_rise", {31'h0, axiBus.BVALID}, 32'h1);
    check("bresp", {30'h0, axiBus.BRESP}, 32'h0);
    for (int i = 0; i < holdB; i++) begin
      axiBus.AWVALID = 1'b1; axiBus.WVALID = 1'b1; #1;
      check("aw_w_blocked_by_bvalid", {30'h0, axiBus.AWREADY, axiBus.WREADY}, 32'h0);
      check("bvalid_hold", {31'h0, axiBus.BVALID}, 32'h1);
      axiBus.AWVALID = 1'b0; axiBus.WVALID = 1'b0;
      @(posedge tb_ACLK); #1;
    end
    axiBus.BREADY = 1'b1;
    @(posedge tb_ACLK); #1;
    axiBus.BREADY = 1'b0;
    check("bvalid_drop", {31'h0, axiBus.BVALID}, 32'h0);
  endtask

  task automatic axiRead(input logic [3:0] addr, input int holdR, output logic [31:0] d,
                         output int arCyc);
    bit got;
    int n;
    axiBus.ARADDR = addr; axiBus.ARVALID = 1'b1;
    got = 0; n = 0; arCyc = cyc;
    while (!got && n < 20) begin
      @(negedge tb_ACLK);
      if (axiBus.ARREADY) begin
        got = 1; arCyc = cyc;
      end
      @(posedge tb_ACLK); #1;
      n++;
    end
    axiBus.ARVALID = 1'b0;
    check("ar_accepted", {31'h0, got}, 32'h1);
    n = 0;
    while (!axiBus.RVALID && n < 20) begin
      @(posedge tb_ACLK); #1; n++;
    end
    check("rvalid_rise", {31'h0, axiBus.RVALID}, 32'h1);
    check("rresp", {30'h0, axiBus.RRESP}, 32'h0);
    d = axiBus.RDATA;
    for (int i = 0; i < holdR; i++) begin
      axiBus.ARVALID = 1'b1; #1;
      check("ar_blocked_by_rvalid", {31'h0, axiBus.ARREADY}, 32'h0);
      check("rdata_stable", axiBus.RDATA, d);
      check("rvalid_hold", {31'h0, axiBus.RVALID}, 32'h1);
      axiBus.ARVALID = 1'b0;
      @(posedge tb_ACLK); #1;
    end
    axiBus.RREADY = 1'b1;
    @(posedge tb_ACLK); #1;
    axiBus.RREADY = 1'b0;
    check("rvalid_drop", {31'h0, axiBus.RVALID}, 32'h0);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] d, output int c);
    axiWrite(addr, d, 4'hF, 0, c);
  endtask

  task automatic rdCheck(input string tag, input logic [3:0] addr);
    logic [31:0] d;
    int c;
    axiRead(addr, 0, d, c);
    check(tag, d, expRead(addr, c));
  endtask

  task automatic checkIdleOutputs(input string tag);
    check(tag, {25'h0, axiBus.AWREADY, axiBus.WREADY, axiBus.BVALID, axiBus.ARREADY,
                axiBus.RVALID, irqOut, |axiBus.RDATA}, 32'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int c, c2;
    logic [31:0] ra, rb, d;
    logic [3:0]  rs;
    bit          ie;

    axiBus.AWADDR = '0; axiBus.AWPROT = '0; axiBus.AWVALID = 1'b0;
    axiBus.WDATA  = '0; axiBus.WSTRB  = '0; axiBus.WVALID  = 1'b0; axiBus.BREADY = 1'b0;
    axiBus.ARADDR = '0; axiBus.ARPROT = '0; axiBus.ARVALID = 1'b0; axiBus.RREADY = 1'b0;
    modelReset();
    repeat (3) @(posedge tb_ACLK);
    #1;
    checkIdleOutputs("reset_outputs");
    tb_ARESETN = 1'b1;
    @(posedge tb_ACLK); #1;
    rdCheck("reset_ctrl", 4'h8);
    rdCheck("reset_result", 4'hC);

    // Register write/readback, including a START hidden in the CTRL pattern.
    wr(4'h0, 32'h0101FFFF, c);
    wr(4'h4, 32'hABCD0001, c);
    wr(4'h8, 32'hDEAD0011, c);
    wr(4'hC, 32'hBEEF0011, c2);
    rdCheck("rb_A", 4'h0);
    rdCheck("rb_B", 4'h4);
    rdCheck("rb_ctrl_busy", 4'h8);
    stepTo(c + 20);
    rdCheck("rb_result_ffff", 4'hC);
    wr(4'h8, 32'h2, c2);
    rdCheck("rb_ctrl_drained", 4'h8);
    rdCheck("rb_result_kept", 4'hC);

    // 3 x 5: still busy in the last busy cycle, then done.
    wr(4'h0, 32'h3, c);
    wr(4'h4, 32'h5, c);
    wr(4'h8, 32'h1, c);
    rdCheck("p35_busy_early", 4'h8);
    stepTo(c + 17);
    rdCheck("p35_busy_last", 4'h8);
    rdCheck("p35_done", 4'h8);
    rdCheck("p35_result", 4'hC);
    check("p35_result_const", expRead(4'hC, cyc), 32'h0000000F);
    wr(4'h8, 32'h2, c2);

    // FFFF x FFFF: done visible exactly 18 cycles after the commit.
    wr(4'h0, 32'hFFFF, c);
    wr(4'h4, 32'hFFFF, c);
    wr(4'h8, 32'h1, c);
    stepTo(c + 18);
    rdCheck("pff_done_at_18", 4'h8);
    rdCheck("pff_result", 4'hC);
    wr(4'h8, 32'h2, c2);
    wr(4'h0, 32'h1234, c);
    wr(4'h4, 32'h0, c);
    wr(4'h8, 32'h1, c);
    stepTo(c + 20);
    rdCheck("pzero_result", 4'hC);
    wr(4'h8, 32'h2, c2);

    // Interrupt: one-cycle lag on rise, clears within two cycles of W1C.
    wr(4'h8, 32'h4, c);
    wr(4'h0, 32'h7, c);
    wr(4'h4, 32'h9, c);
    wr(4'h8, 32'h5, c);
    stepTo(c + 18);
    check("irq_lag", {31'h0, irqOut}, 32'h0);
    stepTo(c + 19);
    check("irq_rise", {31'h0, irqOut}, 32'h1);
    rdCheck("irq_result", 4'hC);
    wr(4'h8, 32'h6, c2);
    check("irq_clear", {31'h0, irqOut}, 32'h0);
    rdCheck("irq_ctrl_after_w1c", 4'h8);
    wr(4'h8, 32'h0, c2);

    // Writes during a run: A changes, second START ignored, single completion.
    wr(4'h0, 32'h2, c);
    wr(4'h4, 32'h3, c);
    wr(4'h8, 32'h1, c);
    wr(4'h0, 32'd100, c2);
    wr(4'h8, 32'h1, c2);
    stepTo(c + 20);
    rdCheck("mid_result", 4'hC);
    rdCheck("mid_A", 4'h0);
    wr(4'h8, 32'h2, c2);
    stepTo(cyc + 40);
    rdCheck("mid_single_done", 4'h8);

    // W1C landing on the FINISH cycle loses to the completion; START+DONE clears and restarts.
    wr(4'h8, 32'h1, c);
    stepTo(c + 17);
    wr(4'h8, 32'h2, c2);
    check("w1c_on_finish_cycle", c2, c + 17);
    rdCheck("set_wins", 4'h8);
    wr(4'h8, 32'h3, c);
    rdCheck("start_and_clear", 4'h8);
    stepTo(c + 20);
    wr(4'h8, 32'h2, c2);

    // Random operands with random byte strobes.
    for (int k = 0; k < 8; k++) begin
      ra = $urandom; rb = $urandom;
      rs = 4'($urandom_range(1, 15));
      ie = 1'($urandom_range(0, 1));
      axiWrite(4'h0, ra, rs, 0, c);
      axiWrite(4'h4, rb, 4'hF, 0, c);
      wr(4'h8, {29'h0, ie, 2'b01}, c);
      rdCheck("rnd_A", 4'h0);
      stepTo(c + 19);
      check("rnd_irq", {31'h0, irqOut}, {31'h0, ie});
      rdCheck("rnd_ctrl", 4'h8);
      rdCheck("rnd_result", 4'hC);
      wr(4'h8, 32'h2, c2);
    end

    // Backpressure on both response channels.
    axiWrite(4'h4, 32'h5A5A_1234, 4'hF, 10, c);
    axiRead(4'h4, 10, d, c);
    check("bp_read_data", d, expRead(4'h4, c));

    // Reset five cycles into a run that is also holding irq high.
    wr(4'h0, 32'h55, c);
    wr(4'h8, 32'h5, c);
    stepTo(c + 20);
    wr(4'h8, 32'h5, c);
    check("pre_reset_irq", {31'h0, irqOut}, 32'h1);
    stepTo(c + 5);
    tb_ARESETN = 1'b0;
    #2;
    checkIdleOutputs("midrun_reset_outputs");
    modelReset();
    repeat (2) @(posedge tb_ACLK);
    #1;
    tb_ARESETN = 1'b1;
    @(posedge tb_ACLK); #1;
    rdCheck("post_reset_ctrl", 4'h8);
    rdCheck("post_reset_result", 4'hC);
    rdCheck("post_reset_A", 4'h0);
    stepTo(cyc + 25);
    rdCheck("post_reset_no_done", 4'h8);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
